mem_port_arbiter: RTL

//  Shares the execution unit's single synchronous main-memory port between the microprogrammed
//  CPU (one word per access) and a DMA/loader engine (bursts of 1..2^LENW words). Sits between the
//  EU memory interface and the memory array. Stalls the control sequencer while the port is busy.

---
 rtl/mem_port_arbiter_if.sv | 49 ++++
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle around the shared main-memory port: CPU requester, DMA requester and memory array.
// The arbiter takes the slave view; the requesters and the memory take the master view.
interface mem_port_arbiter_if #(
   parameter int AW   = 16,
   parameter int DW   = 16,
   parameter int LENW = 4
);
   logic            cpu_req;
   logic            cpu_we;
   logic [AW-1:0]   cpu_addr;
   logic [DW-1:0]   cpu_wdata;
   logic            cpu_stall;
   logic            cpu_rvalid;
   logic [DW-1:0]   cpu_rdata;

   logic            dma_req;
   logic            dma_we;
   logic [AW-1:0]   dma_addr;
   logic [LENW-1:0] dma_len;
   logic [DW-1:0]   dma_wdata;
   logic            dma_ack;
   logic            dma_rvalid;
   logic [DW-1:0]   dma_rdata;
   logic            dma_done;

   logic            mem_en;
   logic            mem_we;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic [DW-1:0]   mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  dma_req, dma_we, dma_addr, dma_len, dma_wdata,
      input  mem_rdata,
      output cpu_stall, cpu_rvalid, cpu_rdata,
      output dma_ack, dma_rvalid, dma_rdata, dma_done,
      output mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output dma_req, dma_we, dma_addr, dma_len, dma_wdata,
      output mem_rdata,
      input  cpu_stall, cpu_rvalid, cpu_rdata,
      input  dma_ack, dma_rvalid, dma_rdata, dma_done,
      input  mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between single-word CPU accesses and committed DMA bursts,
// with a starvation counter that bounds how long a pending DMA burst can lose to the CPU.
module mem_port_arbiter #(
   parameter int AW         = 16,
   parameter int DW         = 16,
   parameter int LENW       = 4,
   parameter int STARVE_LIM = 4
) (
   input logic              clock,
   input logic              reset,
   mem_port_arbiter_if.slave bus
);
   localparam int SW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
   localparam logic [SW-1:0] LIM = SW'(STARVE_LIM);

   typedef enum logic {IDLE, DMA_BURST} state_t;

   state_t          state, state_nx;
   logic [AW-1:0]   base;
   logic [LENW-1:0] len;
   logic [LENW-1:0] idx;
   logic            we_l;
   logic [SW-1:0]   starve_cnt;
   logic            rv_cpu;
   logic            rv_dma;
   logic            done;

   logic            cpu_issue;
   logic            grant;
   logic            last_word;

   always_comb begin
      state_nx      = state;
      cpu_issue     = 1'b0;
      grant         = 1'b0;
      last_word     = 1'b0;
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.dma_ack   = 1'b0;
      if (!reset) begin
         unique case (state)
            IDLE: begin
               // CPU wins unless a DMA request has already lost STARVE_LIM contended cycles
               if (bus.cpu_req && !(bus.dma_req && starve_cnt == LIM)) begin
                  cpu_issue     = 1'b1;
                  bus.mem_en    = 1'b1;
                  bus.mem_we    = bus.cpu_we;
                  bus.mem_addr  = bus.cpu_addr;
                  bus.mem_wdata = bus.cpu_wdata;
               end else if (bus.dma_req) begin
                  grant    = 1'b1;
                  state_nx = DMA_BURST;
               end
            end
            DMA_BURST: begin
               bus.mem_en    = 1'b1;
               bus.mem_we    = we_l;
               bus.mem_addr  = base + AW'(idx);
               bus.mem_wdata = bus.dma_wdata;
               bus.dma_ack   = 1'b1;
               last_word     = (idx == len);
               if (last_word) begin
                  state_nx = IDLE;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
      bus.cpu_stall = bus.cpu_req & ~cpu_issue;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         base       <= '0;
         len        <= '0;
         idx        <= '0;
         we_l       <= 1'b0;
         starve_cnt <= '0;
         rv_cpu     <= 1'b0;
         rv_dma     <= 1'b0;
         done       <= 1'b0;
      end else begin
         state  <= state_nx;
         rv_cpu <= cpu_issue & ~bus.cpu_we;
         rv_dma <= bus.dma_ack & ~we_l;
         done   <= last_word;
         unique case (state)
            IDLE: begin
               if (cpu_issue) begin
                  if (bus.dma_req && starve_cnt != LIM) begin
                     starve_cnt <= starve_cnt + SW'(1);
                  end
               end else if (grant) begin
                  base       <= bus.dma_addr;
                  len        <= bus.dma_len;
                  we_l       <= bus.dma_we;
                  idx        <= '0;
                  starve_cnt <= '0;
               end else begin
                  starve_cnt <= '0;
               end
            end
            DMA_BURST: begin
               starve_cnt <= '0;
               if (!last_word) begin
                  idx <= idx + LENW'(1);
               end
            end
            default: starve_cnt <= '0;
         endcase
      end
   end

   assign bus.cpu_rvalid = rv_cpu;
   assign bus.dma_rvalid = rv_dma;
   assign bus.dma_done   = done;
   assign bus.cpu_rdata  = bus.mem_rdata;
   assign bus.dma_rdata  = bus.mem_rdata;
endmodule
